// File: rtl/adder_word_chain.sv
// Multi-word ripple adder: operand words arrive least-significant first, the carry
// chains across the words of a packet, and result words leave through a 2-entry FIFO.
module adder_word_chain #(
    parameter int MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
    output logic [3:0]  out_idx,
    output logic        err_len
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        last;
        logic        cout;
        logic [3:0]  idx;
    } entry_t;

    localparam logic [3:0] LAST_IDX = 4'(MAX_WORDS - 1);

    state_t      state_reg, state_next;
    logic        carry_reg, carry_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        err_reg, err_next;

    entry_t      fifo_mem [2];
    logic        wr_ptr_reg, rd_ptr_reg;
    logic [1:0]  occ_reg, occ_next;

    logic        push, pop;
    logic        carry_in;
    logic [3:0]  word_idx;
    logic [16:0] word_sum;
    logic        word_final;
    logic        word_overlong;
    entry_t      new_entry;
    entry_t      head;

    assign in_ready = (occ_reg != 2'd2);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // In IDLE no word of the current packet has been seen, so carry and index start from zero.
    assign carry_in      = (state_reg == BUSY) ? carry_reg : 1'b0;
    assign word_idx      = (state_reg == BUSY) ? cnt_reg : 4'd0;
    assign word_sum      = {1'b0, in_a} + {1'b0, in_b} + {16'd0, carry_in};
    assign word_overlong = (word_idx == LAST_IDX) & ~in_last;
    assign word_final    = in_last | (word_idx == LAST_IDX);

    always_comb begin
        new_entry.sum  = word_sum[15:0];
        new_entry.last = word_final;
        new_entry.cout = word_final ? word_sum[16] : 1'b0;
        new_entry.idx  = word_idx;
    end

    always_comb begin
        state_next = state_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        if (push) begin
            if (word_final) begin
                state_next = IDLE;
                carry_next = 1'b0;
                cnt_next   = 4'd0;
                err_next   = err_reg | word_overlong;
            end else begin
                state_next = BUSY;
                carry_next = word_sum[16];
                cnt_next   = word_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            carry_reg <= 1'b0;
            cnt_reg   <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Occupancy bookkeeping; push is only possible below 2 and pop only above 0.
    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            occ_reg <= occ_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr_reg] <= new_entry;
        end
    end

    // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
    assign head      = fifo_mem[rd_ptr_reg];
    assign out_valid = (occ_reg != 2'd0);
    assign out_sum   = out_valid ? head.sum  : 16'd0;
    assign out_last  = out_valid ? head.last : 1'b0;
    assign out_cout  = out_valid ? head.cout : 1'b0;
    assign out_idx   = out_valid ? head.idx  : 4'd0;
    assign err_len   = err_reg;

endmodule

// File: tb/tb_adder_word_chain.sv
// Drives two adder_word_chain instances (MAX_WORDS 16 and 4) with shared stimulus and
// compares every cycle against a big-integer packet model.
module tb_adder_word_chain;

    typedef struct {
        logic [15:0] sum;
        logic        last;
        logic        cout;
        logic [3:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, out_last0, out_cout0, err_len0;
    logic [15:0] out_sum0;
    logic [3:0]  out_idx0;
    logic        in_ready1, out_valid1, out_last1, out_cout1, err_len1;
    logic [15:0] out_sum1;
    logic [3:0]  out_idx1;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic [271:0] pa0, pb0, pa1, pb1;
    int  n0, n1;
    bit  err0, err1;

    always #5 clk = ~clk;

    adder_word_chain #(.MAX_WORDS(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
        .out_last(out_last0), .out_cout(out_cout0), .out_idx(out_idx0),
        .err_len(err_len0)
    );

    adder_word_chain #(.MAX_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
        .out_last(out_last1), .out_cout(out_cout1), .out_idx(out_idx1),
        .err_len(err_len1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet operands are kept as wide integers; word i of the result is simply
    // bits [16i +: 16] of their sum, and the packet carry is the bit above the final word.
    task automatic model_word(input int maxw, input logic [15:0] a, input logic [15:0] b,
                              input bit last, inout logic [271:0] pa, inout logic [271:0] pb,
                              inout int n, inout bit err, output exp_t e);
        logic [271:0] tot;
        bit           fin;
        pa  = pa | (272'(a) << (16 * n));
        pb  = pb | (272'(b) << (16 * n));
        tot = pa + pb;
        fin = last || (n == maxw - 1);
        e.sum  = tot[16 * n +: 16];
        e.idx  = 4'(n);
        e.last = fin;
        e.cout = fin ? tot[16 * n + 16] : 1'b0;
        if (n == maxw - 1 && !last) err = 1'b1;
        if (fin) begin
            pa = '0;
            pb = '0;
            n  = 0;
        end else begin
            n++;
        end
    endtask

    task automatic check_inst(input string nm, input bit jr, input bit exp_err, input exp_t e,
                              input int qsz, input logic rdy, input logic v, input logic [15:0] s,
                              input logic l, input logic c, input logic [3:0] ix, input logic er);
        check({nm, "_in_ready"}, 32'(rdy), 32'(qsz < 2));
        check({nm, "_out_valid"}, 32'(v), 32'(qsz > 0));
        check({nm, "_err_len"}, 32'(er), 32'(exp_err));
        if (qsz > 0) begin
            check({nm, "_out_sum"}, 32'(s), 32'(e.sum));
            check({nm, "_out_last"}, 32'(l), 32'(e.last));
            check({nm, "_out_cout"}, 32'(c), 32'(e.cout));
            check({nm, "_out_idx"}, 32'(ix), 32'(e.idx));
        end else if (jr) begin
            check({nm, "_reset_out"}, {13'd0, s, l, c, ix}, 32'd0);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b, input bit l,
                        input bit ordy, input bit r, output bit acc);
        bit   pop;
        exp_t e0, e1;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = l;
        out_ready = ordy;
        rst       = r;
        acc = v && !r && (q0.size() < 2);
        pop = !r && (q0.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            q0.delete();
            q1.delete();
            pa0 = '0; pb0 = '0; pa1 = '0; pb1 = '0;
            n0 = 0; n1 = 0; err0 = 1'b0; err1 = 1'b0;
        end else begin
            if (pop) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (acc) begin
                model_word(16, a, b, l, pa0, pb0, n0, err0, e0);
                model_word(4, a, b, l, pa1, pb1, n1, err1, e1);
                q0.push_back(e0);
                q1.push_back(e1);
                $display("word a=%04h b=%04h last=%0d -> m16 sum=%04h idx=%0d cout=%0d | m4 sum=%04h idx=%0d last=%0d",
                         a, b, l, e0.sum, e0.idx, e0.cout, e1.sum, e1.idx, e1.last);
            end
        end
        e0 = '{sum: 16'd0, last: 1'b0, cout: 1'b0, idx: 4'd0};
        e1 = e0;
        if (q0.size() > 0) e0 = q0[0];
        if (q1.size() > 0) e1 = q1[0];
        check_inst("m16", r, err0, e0, q0.size(), in_ready0, out_valid0, out_sum0,
                   out_last0, out_cout0, out_idx0, err_len0);
        check_inst("m4", r, err1, e1, q1.size(), in_ready1, out_valid1, out_sum1,
                   out_last1, out_cout1, out_idx1, err_len1);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit l, input bit ordy);
        bit acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            step(1'b1, a, b, l, ordy, 1'b0, acc);
            ordy = 1'b1;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int cycles, input bit ordy);
        bit acc;
        for (int t = 0; t < cycles; t++) begin
            step(1'b0, 16'd0, 16'd0, 1'b0, ordy, 1'b0, acc);
        end
    endtask

    initial begin
        bit acc;
        pa0 = '0; pb0 = '0; pa1 = '0; pb1 = '0;
        n0 = 0; n1 = 0; err0 = 1'b0; err1 = 1'b0;

        step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, acc);
        idle(1, 1'b1);

        // single word with carry-out
        send(16'hFFFF, 16'h0001, 1'b1, 1'b1);
        idle(2, 1'b1);

        // carry propagating into the second word
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        idle(2, 1'b1);

        // backpressure: third word must wait for a free slot
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, acc);
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b0, acc);
            check("bp_held", 32'(acc), 32'd0);
        end
        send(16'h5555, 16'h6666, 1'b1, 1'b1);
        idle(3, 1'b1);

        // overlength on the 4-word instance
        for (int i = 0; i < 5; i++) send(16'h8000, 16'h8000, 1'b0, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        idle(2, 1'b1);
        check("m4_err_sticky", 32'(err_len1), 32'd1);

        // reset in the middle of a packet
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        step(1'b1, 16'h0001, 16'h0001, 1'b1, 1'b1, 1'b1, acc);
        check("m4_err_cleared", 32'(err_len1), 32'd0);
        send(16'h0001, 16'h0001, 1'b1, 1'b1);
        idle(2, 1'b1);

        // full-rate streaming
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i * 16'h1111), 16'hF0F0, (i == 15), 1'b1, 1'b0, acc);
            check("stream_accept", 32'(acc), 32'd1);
        end
        idle(2, 1'b1);

        // randomized traffic
        for (int t = 0; t < 1500; t++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
            step($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, acc);
        end
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_word_chain.md
ADDER_WORD_CHAIN -- requirements
Module: adder_word_chain

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 16, maximum words per packet (2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand word pair present.
REQ-005 SHALL have port in_ready  output  1  block accepts a word pair this cycle.
REQ-006 SHALL have port in_a  input  16  operand A word, least-significant word first.
REQ-007 SHALL have port in_b  input  16  operand B word, least-significant word first.
REQ-008 SHALL have port in_last  input  1  marks most-significant word of packet.
REQ-009 SHALL have port out_valid  output  1  result word present.
REQ-010 SHALL have port out_ready  input  1  downstream consumes result word.
REQ-011 SHALL have port out_sum  output  16  result word.
REQ-012 SHALL have port out_last  output  1  result word is final word of packet.
REQ-013 SHALL have port out_cout  output  1  packet carry-out; meaningful only with out_last, else 0.
REQ-014 SHALL have port out_idx  output  4  word index within packet (0 = LSW).
REQ-015 SHALL have port err_len  output  1  sticky: packet exceeded MAX_WORDS.

Function
REQ-016 SHALL accept an input word pair on a rising edge where in_valid and in_ready are both 1.
REQ-017 SHALL compute per accepted word {cout, sum} = in_a + in_b + carry_reg, 17-bit unsigned, modulo 2^16 for sum.
REQ-018 SHALL hold carry_reg = 0 at the first word of each packet; after a non-final word carry_reg <= cout; after a final word carry_reg <= 0.
REQ-019 SHALL keep a two-state packet FSM: IDLE (no word of current packet accepted) -> BUSY on accepted non-final word; BUSY -> IDLE on accepted final word; IDLE -> IDLE on accepted final word (single-word packet).
REQ-020 SHALL keep a word counter: 0 in IDLE, incremented per accepted non-final word, cleared on accepted final word; out_idx carries the counter value of the word.
REQ-021 SHALL treat the word accepted with counter = MAX_WORDS-1 and in_last = 0 as final (out_last = 1, carry cleared, FSM -> IDLE) and set err_len.
REQ-022 SHALL store results in a 2-entry FIFO holding {sum, last, cout, idx}; out_* present the head entry, out_valid = FIFO non-empty.
REQ-023 SHALL have latency 1: a word accepted at edge N is visible on out_* after edge N when the FIFO was empty.
REQ-024 SHALL drive in_ready = 1 iff FIFO occupancy < 2, derived from registered occupancy only (no combinational path from out_ready).
REQ-025 SHALL pop the head on an edge where out_valid and out_ready are 1; simultaneous push and pop at occupancy 1 SHALL leave occupancy 1 with the new entry at head.
REQ-026 SHALL hold out_* stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL preserve carry_reg, counter and FSM state across cycles with no accepted input (backpressure or idle gaps).
REQ-028 SHALL set out_cout = cout of the final word for final entries and 0 for all other entries.

Reset
REQ-029 SHALL on rst = 1 at a rising edge: FSM -> IDLE, carry_reg = 0, counter = 0, FIFO emptied, err_len = 0, regardless of in-progress packet.
REQ-030 SHALL hold outputs after reset at out_valid = 0, out_sum = 0, out_last = 0, out_cout = 0, out_idx = 0, in_ready = 1.
REQ-031 SHALL ignore in_valid during cycles where rst = 1; err_len SHALL clear only via rst.

Verification
REQ-032 Single word: a=0xFFFF, b=0x0001, last=1 -> next cycle sum=0x0000, last=1, cout=1, idx=0.
REQ-033 Two-word carry: (0xFFFF,0x0001,last=0),(0x0000,0x0000,last=1) -> sums 0x0000 idx0 cout0, then 0x0001 idx1 last=1 cout=0.
REQ-034 Backpressure: out_ready=0, three back-to-back words -> in_ready low after second accept, third held; outputs stable; release -> all three in order, no loss/duplication.
REQ-035 Overlength with MAX_WORDS=4: five words (0x8000,0x8000,last=0) -> fourth has idx3, last=1, cout=1; err_len=1; fifth starts new packet idx0 with carry 0 (sum=0x0000).
REQ-036 Reset mid-packet: after first word (0xFFFF,0x0001,last=0) assert rst one cycle -> FIFO empty, then (0x0001,0x0001,last=1) -> sum=0x0002, idx0, cout0.
REQ-037 Streaming at full rate with out_ready=1: 16 words accepted in 16 consecutive cycles, in_ready constantly 1, results one cycle behind.
